predecode_fetch_queue: RTL and testbench

//  Instruction queue between the fetch stage and the decoder. It buffers fetched
//  {pc, instruction, fetch fault} entries in a DEPTH-entry FIFO and predecodes each

---
 rtl/predecode_fetch_queue.sv | 209 ++++++++++++++++++++
 tb/tb_predecode_fetch_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/predecode_fetch_queue.sv
// predecode_fetch_queue
//   Instruction queue between fetch and decode. Buffers {pc, instr, fetch fault}
//   entries in a DEPTH-entry FIFO and predecodes each entry as it is pushed:
//   major opcode class, exception flag and exception cause. The register
//   fields are sliced from the stored instruction at the head. A synchronous
//   flush empties the queue on redirect.
//
// Ports
//   clk_i, rst_i            clock / asynchronous active-high reset
//   flush_i                 synchronous flush, highest priority
//   in_valid_i/in_ready_o   fetch-side handshake (in_ready_o = !full)
//   in_pc_i/in_instr_i/in_xcpt_i   fetched entry
//   out_valid_o/out_ready_i decode-side handshake (out_valid_o = !empty)
//   out_pc_o/out_instr_o    head entry
//   out_class_o             predecoded class, 4'hF when empty
//   out_rs1_o/out_rs2_o/out_rd_o   register fields of the head instruction
//   out_xcpt_o/out_cause_o  head exception, cause 'hFF when none or empty
//   count_o                 occupied entries
module predecode_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          in_pc_i,
    input  logic [31:0]              in_instr_i,
    input  logic                     in_xcpt_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [31:0]              out_instr_o,
    output logic [3:0]               out_class_o,
    output logic [4:0]               out_rs1_o,
    output logic [4:0]               out_rs2_o,
    output logic [4:0]               out_rd_o,
    output logic                     out_xcpt_o,
    output logic [XLEN-1:0]          out_cause_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_BRANCH  = 4'd1,
        CLS_JUMP    = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_SYSTEM  = 4'd5,
        CLS_FP      = 4'd6,
        CLS_VECTOR  = 4'd7,
        CLS_ATOMIC  = 4'd8,
        CLS_BS      = 4'd9,
        CLS_ILLEGAL = 4'd15
    } iclass_e;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_ALU      = 7'b0110011;
    localparam logic [6:0] OP_ALU_I    = 7'b0010011;
    localparam logic [6:0] OP_ALU_W    = 7'b0111011;
    localparam logic [6:0] OP_ALU_I_W  = 7'b0011011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_FENCE    = 7'b0001111;
    localparam logic [6:0] OP_FP       = 7'b1010011;
    localparam logic [6:0] OP_FMADD    = 7'b1000011;
    localparam logic [6:0] OP_FMSUB    = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OP_FNMADD   = 7'b1001111;
    localparam logic [6:0] OP_V        = 7'b1010111;
    localparam logic [6:0] OP_ATOMIC   = 7'b0101111;
    localparam logic [6:0] OP_BS       = 7'b0101011;

    localparam logic [XLEN-1:0] CAUSE_FETCH   = XLEN'(8'h01);
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(8'h02);
    localparam logic [XLEN-1:0] CAUSE_NONE    = XLEN'(8'hFF);

    // Storage
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    iclass_e         class_q [DEPTH];
    logic            xcpt_q  [DEPTH];
    logic [XLEN-1:0] cause_q [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;

    logic full, empty, push, pop;
    logic [AW-1:0] wr_idx, rd_idx;

    iclass_e         in_class;
    logic            in_is_xcpt;
    logic [XLEN-1:0] in_cause;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign in_ready_o  = !full;
    assign out_valid_o = !empty;

    // Push is gated by !full only, so a pop cannot make room in the same cycle.
    assign push = in_valid_i && !full && !flush_i;
    assign pop  = !empty && out_ready_i && !flush_i;

    assign count_o = wr_ptr_q - rd_ptr_q;

    // Predecode of the incoming entry
    always_comb begin
        in_class = CLS_ILLEGAL;
        case (in_instr_i[6:0])
            OP_LUI, OP_AUIPC, OP_ALU, OP_ALU_I, OP_ALU_W, OP_ALU_I_W:
                in_class = CLS_ALU;
            OP_BRANCH:                 in_class = CLS_BRANCH;
            OP_JAL, OP_JALR:           in_class = CLS_JUMP;
            OP_LOAD, OP_LOAD_FP:       in_class = CLS_LOAD;
            OP_STORE, OP_STORE_FP:     in_class = CLS_STORE;
            OP_SYSTEM, OP_FENCE:       in_class = CLS_SYSTEM;
            OP_FP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD:
                in_class = CLS_FP;
            OP_V:                      in_class = CLS_VECTOR;
            OP_ATOMIC:                 in_class = CLS_ATOMIC;
            OP_BS:                     in_class = CLS_BS;
            default:                   in_class = CLS_ILLEGAL;
        endcase

        // Fetch fault outranks illegal opcode; class is recorded either way.
        in_is_xcpt = in_xcpt_i || (in_class == CLS_ILLEGAL);
        if (in_xcpt_i) begin
            in_cause = CAUSE_FETCH;
        end else if (in_class == CLS_ILLEGAL) begin
            in_cause = CAUSE_ILLEGAL;
        end else begin
            in_cause = CAUSE_NONE;
        end
    end

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry payload needs no reset: head outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_q[wr_idx]    <= in_pc_i;
            instr_q[wr_idx] <= in_instr_i;
            class_q[wr_idx] <= in_class;
            xcpt_q[wr_idx]  <= in_is_xcpt;
            cause_q[wr_idx] <= in_cause;
        end
    end

    // Head outputs
    always_comb begin
        out_pc_o    = '0;
        out_instr_o = '0;
        out_class_o = CLS_ILLEGAL;
        out_rs1_o   = '0;
        out_rs2_o   = '0;
        out_rd_o    = '0;
        out_xcpt_o  = 1'b0;
        out_cause_o = CAUSE_NONE;
        if (!empty) begin
            out_pc_o    = pc_q[rd_idx];
            out_instr_o = instr_q[rd_idx];
            out_class_o = class_q[rd_idx];
            out_rs1_o   = instr_q[rd_idx][19:15];
            out_rs2_o   = instr_q[rd_idx][24:20];
            out_rd_o    = instr_q[rd_idx][11:7];
            out_xcpt_o  = xcpt_q[rd_idx];
            out_cause_o = cause_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_predecode_fetch_queue.sv
// Testbench for predecode_fetch_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_predecode_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [XLEN-1:0]   in_pc_i;
    logic [31:0]       in_instr_i;
    logic              in_xcpt_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   out_pc_o;
    logic [31:0]       out_instr_o;
    logic [3:0]        out_class_o;
    logic [4:0]        out_rs1_o;
    logic [4:0]        out_rs2_o;
    logic [4:0]        out_rd_o;
    logic              out_xcpt_o;
    logic [XLEN-1:0]   out_cause_o;
    logic [2:0]        count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        xcpt;
    } ent_t;

    ent_t mq[$];

    logic [6:0] legal_ops [0:22] = '{
        7'h37, 7'h17, 7'h33, 7'h13, 7'h3B, 7'h1B, 7'h63, 7'h6F, 7'h67, 7'h03,
        7'h07, 7'h23, 7'h27, 7'h73, 7'h0F, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F,
        7'h57, 7'h2F, 7'h2B
    };

    predecode_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_pc_i     (in_pc_i),
        .in_instr_i  (in_instr_i),
        .in_xcpt_i   (in_xcpt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pc_o    (out_pc_o),
        .out_instr_o (out_instr_o),
        .out_class_o (out_class_o),
        .out_rs1_o   (out_rs1_o),
        .out_rs2_o   (out_rs2_o),
        .out_rd_o    (out_rd_o),
        .out_xcpt_o  (out_xcpt_o),
        .out_cause_o (out_cause_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Class table from the opcode map
    function automatic logic [3:0] ref_class(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        case (op)
            7'h37, 7'h17, 7'h33, 7'h13, 7'h3B, 7'h1B: return 4'd0;
            7'h63:                                    return 4'd1;
            7'h6F, 7'h67:                             return 4'd2;
            7'h03, 7'h07:                             return 4'd3;
            7'h23, 7'h27:                             return 4'd4;
            7'h73, 7'h0F:                             return 4'd5;
            7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F:        return 4'd6;
            7'h57:                                    return 4'd7;
            7'h2F:                                    return 4'd8;
            7'h2B:                                    return 4'd9;
            default:                                  return 4'd15;
        endcase
    endfunction

    function automatic logic [63:0] ref_cause(input ent_t e);
        if (e.xcpt) return 64'h01;
        if (ref_class(e.instr) == 4'd15) return 64'h02;
        return 64'hFF;
    endfunction

    // One clock of stimulus; the model is advanced with the same decision rules.
    task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                         input logic x, input logic rdy, input logic fl);
        bit   do_push, do_pop;
        ent_t e;
        in_valid_i  = v;
        in_pc_i     = pc;
        in_instr_i  = instr;
        in_xcpt_i   = x;
        out_ready_i = rdy;
        flush_i     = fl;
        do_push = v && (mq.size() < DEPTH) && !fl;
        do_pop  = (mq.size() > 0) && rdy && !fl;
        @(posedge clk_i);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc = pc; e.instr = instr; e.xcpt = x;
                mq.push_back(e);
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        in_xcpt_i   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 64'h0, 32'h0, 0, 1, 0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 0; in_valid_i = 0; out_ready_i = 0;
        in_pc_i = '0; in_instr_i = '0; in_xcpt_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h want 1", in_ready_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        checks++; if (out_cause_o !== 64'hFF) begin errors++; $display("FAIL reset_cause got %0h want ff", out_cause_o); end
        checks++; if (out_class_o !== 4'hF) begin errors++; $display("FAIL reset_class got %0h want f", out_class_o); end
        checks++; if (out_pc_o !== 64'h0) begin errors++; $display("FAIL reset_pc got %0h want 0", out_pc_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mq.delete();
    endtask

    task automatic test_basic();
        cycle(1, 64'h8000_0000, 32'h00500093, 0, 0, 0);
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h want 1", out_valid_o); end
        checks++; if (out_class_o !== 4'd0) begin errors++; $display("FAIL basic_class got %0h want 0", out_class_o); end
        checks++; if (out_rd_o !== 5'd1) begin errors++; $display("FAIL basic_rd got %0d want 1", out_rd_o); end
        checks++; if (out_rs1_o !== 5'd0) begin errors++; $display("FAIL basic_rs1 got %0d want 0", out_rs1_o); end
        checks++; if (out_xcpt_o !== 1'b0) begin errors++; $display("FAIL basic_xcpt got %0h want 0", out_xcpt_o); end
        checks++; if (out_cause_o !== 64'hFF) begin errors++; $display("FAIL basic_cause got %0h want ff", out_cause_o); end
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL basic_count got %0d want 1", count_o); end
        checks++; if (out_pc_o !== 64'h8000_0000) begin errors++; $display("FAIL basic_pc got %0h want 80000000", out_pc_o); end
        cycle(0, 64'h0, 32'h0, 0, 1, 0);
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drained got %0h want 0", out_valid_o); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) cycle(1, 64'h1000 + 64'(4 * i), 32'h00500093, 0, 0, 0);
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0h want 0", in_ready_o); end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count_o); end
        cycle(1, 64'h2000, 32'h00500093, 0, 0, 0);
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_refuse_count got %0d want 4", count_o); end
        checks++; if (out_pc_o !== 64'h1000) begin errors++; $display("FAIL full_refuse_head got %0h want 1000", out_pc_o); end
        cycle(1, 64'h3000, 32'h00500093, 0, 1, 0);
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_poppush_count got %0d want 3", count_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL full_poppush_ready got %0h want 1", in_ready_o); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (out_pc_o !== 64'h1000 + 64'(4 * i)) begin errors++; $display("FAIL full_order got %0h want %0h", out_pc_o, 64'h1000 + 64'(4 * i)); end
            cycle(0, 64'h0, 32'h0, 0, 1, 0);
        end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL full_refused_not_stored got %0h want 0", out_valid_o); end
    endtask

    task automatic test_exceptions();
        cycle(1, 64'h4000, 32'h0000006B, 0, 0, 0);
        checks++; if (out_class_o !== 4'hF) begin errors++; $display("FAIL illegal_class got %0h want f", out_class_o); end
        checks++; if (out_xcpt_o !== 1'b1) begin errors++; $display("FAIL illegal_xcpt got %0h want 1", out_xcpt_o); end
        checks++; if (out_cause_o !== 64'h02) begin errors++; $display("FAIL illegal_cause got %0h want 2", out_cause_o); end
        cycle(1, 64'h4004, 32'h0000202B, 1, 1, 0);
        checks++; if (out_class_o !== 4'd9) begin errors++; $display("FAIL bs_class got %0h want 9", out_class_o); end
        checks++; if (out_xcpt_o !== 1'b1) begin errors++; $display("FAIL bs_xcpt got %0h want 1", out_xcpt_o); end
        checks++; if (out_cause_o !== 64'h01) begin errors++; $display("FAIL bs_cause got %0h want 1", out_cause_o); end
        cycle(1, 64'h4008, 32'h0000006B, 1, 1, 0);
        checks++; if (out_cause_o !== 64'h01) begin errors++; $display("FAIL prio_cause got %0h want 1", out_cause_o); end
        drain();
    endtask

    task automatic test_back_to_back();
        cycle(1, 64'h5000, 32'h00A00113, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cycle(1, 64'h5000 + 64'(4 * i), 32'h00A00113, 0, 1, 0);
            checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", i, count_o); end
            checks++; if (out_pc_o !== 64'h5000 + 64'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %0h want %0h", i, out_pc_o, 64'h5000 + 64'(4 * i)); end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1, 64'h6000 + 64'(4 * i), 32'h00000063, 0, 0, 0);
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count_o); end
        cycle(1, 64'h6100, 32'h00000063, 0, 1, 1);
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h want 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %0h want 1", in_ready_o); end
        cycle(0, 64'h0, 32'h0, 0, 0, 0);
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_entry_dropped got %0h want 0", out_valid_o); end
        cycle(1, 64'h6200, 32'h00000063, 0, 0, 0);
        checks++; if (out_pc_o !== 64'h6200) begin errors++; $display("FAIL flush_refill_pc got %0h want 6200", out_pc_o); end
        checks++; if (out_class_o !== 4'd1) begin errors++; $display("FAIL flush_refill_class got %0h want 1", out_class_o); end
        drain();
    endtask

    task automatic test_random();
        logic        v, rdy, fl, x;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        ev;
        ent_t        h;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom % 4) != 0;
            rdy = (i < 200) ? (($urandom % 3) == 0) : (($urandom % 3) != 0);
            fl  = ($urandom % 40) == 0;
            x   = ($urandom % 8) == 0;
            instr = $urandom;
            if (($urandom % 6) != 0) instr[6:0] = legal_ops[$urandom % 23];
            pc = {32'h0, $urandom} & ~64'h3;
            cycle(v, pc, instr, x, rdy, fl);
            ev = mq.size() != 0;
            if (ev) h = mq[0];
            checks++; if (out_valid_o !== ev) begin errors++; $display("FAIL rnd_valid[%0d] got %0h want %0h", i, out_valid_o, ev); end
            checks++; if (count_o !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count_o, mq.size()); end
            checks++; if (in_ready_o !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d] got %0h", i, in_ready_o); end
            if (ev) begin
                checks++; if (out_pc_o !== h.pc) begin errors++; $display("FAIL rnd_pc[%0d] got %0h want %0h", i, out_pc_o, h.pc); end
                checks++; if (out_instr_o !== h.instr) begin errors++; $display("FAIL rnd_instr[%0d] got %0h want %0h", i, out_instr_o, h.instr); end
                checks++; if (out_class_o !== ref_class(h.instr)) begin errors++; $display("FAIL rnd_class[%0d] got %0h want %0h", i, out_class_o, ref_class(h.instr)); end
                checks++; if ({out_rs1_o, out_rs2_o, out_rd_o} !== {h.instr[19:15], h.instr[24:20], h.instr[11:7]}) begin errors++; $display("FAIL rnd_regs[%0d] got %0h/%0h/%0h", i, out_rs1_o, out_rs2_o, out_rd_o); end
                checks++; if (out_cause_o !== ref_cause(h)) begin errors++; $display("FAIL rnd_cause[%0d] got %0h want %0h", i, out_cause_o, ref_cause(h)); end
                checks++; if (out_xcpt_o !== (ref_cause(h) != 64'hFF)) begin errors++; $display("FAIL rnd_xcpt[%0d] got %0h", i, out_xcpt_o); end
            end else begin
                checks++; if ({out_pc_o, out_instr_o, out_xcpt_o} !== '0) begin errors++; $display("FAIL rnd_empty_data[%0d] got %0h", i, out_pc_o); end
                checks++; if ({out_class_o, out_cause_o} !== {4'hF, 64'hFF}) begin errors++; $display("FAIL rnd_empty_meta[%0d] got %0h/%0h", i, out_class_o, out_cause_o); end
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        cycle(1, 64'h7000, 32'h00500093, 0, 0, 0);
        cycle(1, 64'h7004, 32'h00500093, 0, 0, 0);
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL areset_pre_count got %0d want 2", count_o); end
        #3;
        rst_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid got %0h want 0", out_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL areset_count got %0d want 0", count_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL areset_ready got %0h want 1", in_ready_o); end
        mq.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cycle(0, 64'h0, 32'h0, 0, 0, 0);
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL areset_post_valid got %0h want 0", out_valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_exceptions();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
